// File: rtl/response_control.sv
// Receive side of the PSL response interface: response register/decode, tag parity,
// AFU command credit pool and the PAGED/restart recovery FSM that gates command issue.
module response_control #(
    parameter int         CREDIT_WIDTH = 8,
    parameter logic [7:0] RESTART_TAG  = 8'hFF
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic                    enabled_in,
    input  logic [CREDIT_WIDTH-1:0] credits_init_in,
    input  logic                    ha_rvalid,
    input  logic [7:0]              ha_rtag,
    input  logic                    ha_rtagpar,
    input  logic [7:0]              ha_response,
    input  logic [8:0]              ha_rcredits,
    input  logic                    command_issued_in,
    input  logic                    restart_ack_in,
    output logic                    rsp_valid_out,
    output logic [7:0]              rsp_tag_out,
    output logic                    rsp_done,
    output logic                    rsp_flushed,
    output logic                    rsp_paged,
    output logic                    rsp_error_out,
    output logic [CREDIT_WIDTH-1:0] credits_out,
    output logic                    credit_avail_out,
    output logic                    restart_req_out,
    output logic                    tag_parity_err_out,
    output logic                    credit_err_out
);

    localparam int STAGES = 2;
    localparam int SW     = CREDIT_WIDTH + 2;
    localparam logic signed [SW-1:0] CRED_MAX = SW'((1 << CREDIT_WIDTH) - 1);

    typedef struct packed {
        logic [7:0] tag;
        logic       tagpar;
        logic [7:0] code;
        logic [8:0] rcredits;
    } rsp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    logic                    enabled_q;
    logic                    init_done_q;
    logic [STAGES:1]         vld_pipe;
    rsp_t                    s1_q;
    state_t                  state_q, state_d;
    logic [CREDIT_WIDTH-1:0] credits_q;
    logic signed [SW-1:0]    cred_ret, cred_iss, cred_sum;
    logic                    s1_done, s1_flushed, s1_paged, s1_error, s1_par_bad;

    // S1 capture; S2 registers are the response outputs themselves
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled_q          <= 1'b0;
            vld_pipe           <= '0;
            s1_q               <= '0;
            rsp_tag_out        <= '0;
            rsp_done           <= 1'b0;
            rsp_flushed        <= 1'b0;
            rsp_paged          <= 1'b0;
            rsp_error_out      <= 1'b0;
            tag_parity_err_out <= 1'b0;
        end else begin
            enabled_q     <= enabled_in;
            vld_pipe      <= {vld_pipe[1], ha_rvalid & enabled_q};
            if (enabled_q) begin
                s1_q.tag      <= ha_rtag;
                s1_q.tagpar   <= ha_rtagpar;
                s1_q.code     <= ha_response;
                s1_q.rcredits <= ha_rcredits;
            end
            rsp_tag_out   <= s1_q.tag;
            rsp_done      <= vld_pipe[1] & s1_done;
            rsp_flushed   <= vld_pipe[1] & s1_flushed;
            rsp_paged     <= vld_pipe[1] & s1_paged;
            rsp_error_out <= vld_pipe[1] & s1_error;
            if (vld_pipe[1] && s1_par_bad)
                tag_parity_err_out <= 1'b1;
        end
    end

    assign rsp_valid_out = vld_pipe[STAGES];
    assign s1_par_bad    = ~^{s1_q.tag, s1_q.tagpar};

    always_comb begin
        s1_done    = 1'b0;
        s1_flushed = 1'b0;
        s1_paged   = 1'b0;
        s1_error   = 1'b0;
        case (s1_q.code)
            8'h00:   s1_done    = 1'b1;
            8'h06:   s1_flushed = 1'b1;
            8'h0A:   s1_paged   = 1'b1;
            default: s1_error   = 1'b1;
        endcase
    end

    // Signed sum wide enough that neither underflow nor overflow can wrap
    always_comb begin
        cred_ret = vld_pipe[1] ? SW'($signed(s1_q.rcredits)) : '0;
        cred_iss = (command_issued_in && enabled_q) ? SW'(1) : '0;
        cred_sum = $signed({2'b00, credits_q}) + cred_ret - cred_iss;
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            credits_q      <= '0;
            init_done_q    <= 1'b0;
            credit_err_out <= 1'b0;
        end else if (!init_done_q) begin
            if (enabled_q) begin
                credits_q   <= credits_init_in;
                init_done_q <= 1'b1;
            end
        end else if (cred_sum[SW-1]) begin
            credits_q      <= '0;
            credit_err_out <= 1'b1;
        end else if (cred_sum > CRED_MAX) begin
            credits_q      <= CRED_MAX[CREDIT_WIDTH-1:0];
            credit_err_out <= 1'b1;
        end else begin
            credits_q <= cred_sum[CREDIT_WIDTH-1:0];
        end
    end

    assign credits_out = credits_q;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Recovery reacts to the response as presented at the outputs
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (rsp_valid_out && rsp_paged) state_d = FLUSH;
            FLUSH: if (restart_ack_in) state_d = WAIT;
            WAIT: begin
                if (rsp_valid_out && rsp_paged)
                    state_d = FLUSH;
                else if (rsp_valid_out && (rsp_done || rsp_error_out) &&
                         rsp_tag_out == RESTART_TAG)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign restart_req_out  = (state_q == FLUSH);
    assign credit_avail_out = (|credits_q) && (state_q == IDLE);

endmodule
